// File: rtl/serialtopara_rx.sv
`default_nettype none
// ============================================================================
// Module   : serialtopara_rx
// Purpose  : Single-lane serial-to-parallel receive stage. Searches the MSB-
//            first bit stream for the COM symbol, declares word lock after
//            SYNC_COUNT consecutive word-aligned COMs, then strips COM (and
//            optionally IDLE) words and stores payload words in a small
//            receive FIFO whose almost-full flag back-pressures the sender.
// Ports    : clk             - bit clock (single clock domain)
//            reset           - synchronous, active-low reset
//            in              - serial data, MSB first
//            pop             - consumer read request
//            out             - registered word popped from the FIFO
//            valid_out       - out holds a word popped at the previous edge
//            fifo_empty      - FIFO occupancy is zero
//            fifo_almostfull - occupancy >= AF_THRESHOLD (back-pressure)
//            active          - word lock achieved
//            Error           - sticky FIFO overflow flag
// Options  : SERIALTOPARA_IDLE_DROP_EN - when defined, IDLE words received
//            while locked are discarded like COM; otherwise stored as payload.
// Revision : 1.0 - initial release
// ============================================================================
module serialtopara_rx #(
    parameter int                   DATA_SIZE    = 8,
    parameter int                   FIFO_DEPTH   = 4,
    parameter int                   AF_THRESHOLD = 3,
    parameter logic [DATA_SIZE-1:0] COM          = 8'hBC,
    parameter logic [DATA_SIZE-1:0] IDLE         = 8'h7C,
    parameter int                   SYNC_COUNT   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] out,
    output logic                 valid_out,
    output logic                 fifo_empty,
    output logic                 fifo_almostfull,
    output logic                 active,
    output logic                 Error
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_BW = $clog2(DATA_SIZE);
    localparam int c_SW = $clog2(SYNC_COUNT + 1);

`ifdef SERIALTOPARA_IDLE_DROP_EN
    localparam logic c_IDLE_DROP = 1'b1;
`else
    localparam logic c_IDLE_DROP = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_SIZE-2:0]   r_sr;
    logic [c_BW-1:0]        r_bitcnt;
    logic [c_BW-1:0]        w_bitcnt_nxt;
    logic [c_SW-1:0]        r_comcnt;
    logic [c_SW-1:0]        w_comcnt_nxt;
    logic [DATA_SIZE-1:0]   w_word;
    logic                   w_boundary;
    logic                   w_is_com;
    logic                   w_drop_idle;
    logic                   w_payload;

    logic [DATA_SIZE-1:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]        r_wptr;
    logic [c_AW-1:0]        r_rptr;
    logic [c_CW-1:0]        r_count;
    logic [c_CW-1:0]        w_count_nxt;
    logic                   w_full;
    logic                   w_do_pop;
    logic                   w_push;
    logic                   w_overflow;
    logic [DATA_SIZE-1:0]   r_out;
    logic                   r_valid;
    logic                   r_empty;
    logic                   r_af;
    logic                   r_error;

    // Candidate word: the previous DATA_SIZE-1 bits plus the bit on the wire.
    assign w_word      = {r_sr, in};
    assign w_boundary  = (r_bitcnt == c_BW'(DATA_SIZE - 1));
    assign w_is_com    = (w_word == COM);
    assign w_drop_idle = c_IDLE_DROP & (w_word == IDLE);

    // ---------------- word alignment FSM ----------------
    always_comb begin
        w_state_nxt  = r_state;
        w_comcnt_nxt = r_comcnt;
        w_bitcnt_nxt = w_boundary ? '0 : r_bitcnt + 1'b1;
        w_payload    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                // Bit-by-bit hunt; a hit defines the new word phase.
                if (w_is_com) begin
                    w_state_nxt  = ST_ALIGN;
                    w_comcnt_nxt = c_SW'(1);
                    w_bitcnt_nxt = '0;
                end
            end
            ST_ALIGN: begin
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_comcnt_nxt = r_comcnt + 1'b1;
                        if (r_comcnt == c_SW'(SYNC_COUNT - 1)) begin
                            w_state_nxt = ST_ACTIVE;
                        end
                    end else begin
                        w_state_nxt  = ST_SEARCH;
                        w_comcnt_nxt = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Lock is never lost here; only reset leaves this state.
                w_payload = w_boundary && !w_is_com && !w_drop_idle;
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_SEARCH;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_comcnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sr     <= w_word[DATA_SIZE-2:0];
            r_bitcnt <= w_bitcnt_nxt;
            r_comcnt <= w_comcnt_nxt;
        end
    end

    // ---------------- receive FIFO ----------------
    assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
    assign w_do_pop   = pop && !r_empty;
    // A pop at the same edge frees the slot, so a full FIFO still accepts.
    assign w_push     = w_payload && (!w_full || w_do_pop);
    assign w_overflow = w_payload && w_full && !w_do_pop;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // When full, wptr == rptr: the registered read below still returns the
    // old entry because both use pre-edge values.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_empty <= 1'b1;
            r_af    <= 1'b0;
            r_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_out  <= r_mem[r_rptr];
            end
            r_valid <= w_do_pop;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_af    <= (w_count_nxt >= c_CW'(AF_THRESHOLD));
            if (w_overflow) begin
                r_error <= 1'b1;
            end
        end
    end

    assign out             = r_out;
    assign valid_out       = r_valid;
    assign fifo_empty      = r_empty;
    assign fifo_almostfull = r_af;
    assign active          = (r_state == ST_ACTIVE);
    assign Error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_serialtopara_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serialtopara_rx
// Purpose  : Self-checking bench for serialtopara_rx. Stimulus pushes the
//            words expected to come out of the FIFO into a queue; a monitor
//            compares every valid_out word against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serialtopara_rx;

    localparam logic [7:0] c_COM  = 8'hBC;
    localparam logic [7:0] c_IDLE = 8'h7C;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_s;
    logic       pop_s;
    logic [7:0] out_w;
    logic       valid_out_w;
    logic       fifo_empty_w;
    logic       fifo_af_w;
    logic       active_w;
    logic       error_w;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    serialtopara_rx dut (
        .clk             (clk),
        .reset           (reset),
        .in              (in_s),
        .pop             (pop_s),
        .out             (out_w),
        .valid_out       (valid_out_w),
        .fifo_empty      (fifo_empty_w),
        .fifo_almostfull (fifo_af_w),
        .active          (active_w),
        .Error           (error_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every popped word must match the queue head.
    always @(negedge clk) begin
        if (reset === 1'b1 && valid_out_w === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_unexpected: got %0h, expected no word", out_w);
            end else begin
                check("out_word", {24'd0, out_w}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_bits(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            in_s = b;
            @(posedge clk); #1;
        end
    endtask

    // pop_at: bit index (7..0) at whose sampling edge pop is high; -1 = none.
    task automatic send_word(input logic [7:0] w, input int pop_at);
        for (int i = 7; i >= 0; i--) begin
            in_s  = w[i];
            pop_s = (i == pop_at);
            @(posedge clk); #1;
            pop_s = 1'b0;
        end
    endtask

    // Pop while streaming a COM word so a locked receiver stores nothing.
    task automatic pop_word(input logic exp_v);
        for (int i = 7; i >= 0; i--) begin
            in_s  = c_COM[i];
            pop_s = (i == 7);
            @(posedge clk); #1;
            pop_s = 1'b0;
            if (i == 7) check("pop_valid", {31'd0, valid_out_w}, {31'd0, exp_v});
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        in_s  = 1'b0;
        pop_s = 1'b0;
        exp_q.delete();
        repeat (n) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
    endtask

    task automatic lock4;
        for (int k = 0; k < 4; k++) send_word(c_COM, -1);
    endtask

    initial begin
        reset = 1'b0;
        in_s  = 1'b0;
        pop_s = 1'b0;

        // Reset state
        do_reset(3);
        check("rst_out",       {24'd0, out_w},        32'd0);
        check("rst_valid",     {31'd0, valid_out_w},  32'd0);
        check("rst_empty",     {31'd0, fifo_empty_w}, 32'd1);
        check("rst_af",        {31'd0, fifo_af_w},    32'd0);
        check("rst_active",    {31'd0, active_w},     32'd0);
        check("rst_error",     {31'd0, error_w},      32'd0);
        send_bits(1'b0, 16);
        check("zeros_active",  {31'd0, active_w},     32'd0);

        // Misaligned prefix, lock, one payload word
        send_bits(1'b1, 1); send_bits(1'b0, 1); send_bits(1'b1, 1);
        send_word(c_COM, -1); send_word(c_COM, -1); send_word(c_COM, -1);
        send_word(c_COM, 0);
        check("lock_active",   {31'd0, active_w},     32'd1);
        exp_q.push_back(8'h55);
        send_word(8'h55, -1);
        check("w55_empty",     {31'd0, fifo_empty_w}, 32'd0);
        pop_word(1'b1);

        // Broken alignment run does not lock
        do_reset(2);
        send_bits(1'b0, 8);
        send_word(c_COM, -1); send_word(c_COM, -1); send_word(c_COM, -1);
        send_word(8'h12, -1);
        check("brk_active",    {31'd0, active_w},     32'd0);
        lock4();
        check("relock_active", {31'd0, active_w},     32'd1);
        check("x12_not_stored",{31'd0, fifo_empty_w}, 32'd1);

        // Fill, almost-full, overflow
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back(8'(k));
            send_word(8'(k), -1);
            if (k == 2) check("af_after2",  {31'd0, fifo_af_w}, 32'd0);
            if (k == 3) check("af_after3",  {31'd0, fifo_af_w}, 32'd1);
            if (k == 4) check("err_after4", {31'd0, error_w},   32'd0);
        end
        check("err_after5",    {31'd0, error_w},      32'd1);
        for (int k = 0; k < 4; k++) pop_word(1'b1);
        check("drained_empty", {31'd0, fifo_empty_w}, 32'd1);
        check("drained_af",    {31'd0, fifo_af_w},    32'd0);
        pop_word(1'b0);

        // IDLE handling
`ifdef SERIALTOPARA_IDLE_DROP_EN
        exp_q.push_back(8'hAA);
        send_word(c_IDLE, -1);
        send_word(8'hAA, -1);
        pop_word(1'b1);
`else
        exp_q.push_back(c_IDLE);
        exp_q.push_back(8'hAA);
        send_word(c_IDLE, -1);
        send_word(8'hAA, -1);
        pop_word(1'b1);
        pop_word(1'b1);
`endif
        check("idle_empty",    {31'd0, fifo_empty_w}, 32'd1);

        // Full FIFO with simultaneous push and pop
        do_reset(2);
        check("rst2_error",    {31'd0, error_w},      32'd0);
        send_bits(1'b0, 8);
        lock4();
        exp_q.push_back(8'h11); send_word(8'h11, -1);
        exp_q.push_back(8'h22); send_word(8'h22, -1);
        exp_q.push_back(8'h33); send_word(8'h33, -1);
        exp_q.push_back(8'h44); send_word(8'h44, -1);
        check("full_af",       {31'd0, fifo_af_w},    32'd1);
        exp_q.push_back(8'h66);
        send_word(8'h66, 0);
        check("pp_error",      {31'd0, error_w},      32'd0);
        check("pp_af",         {31'd0, fifo_af_w},    32'd1);
        for (int k = 0; k < 4; k++) pop_word(1'b1);
        check("pp_empty",      {31'd0, fifo_empty_w}, 32'd1);

        // Reset mid-word discards contents and lock
        exp_q.push_back(8'h77);
        send_word(8'h77, -1);
        check("x77_empty",     {31'd0, fifo_empty_w}, 32'd0);
        send_bits(1'b1, 4);
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_active", {31'd0, active_w},     32'd0);
        check("midrst_empty",  {31'd0, fifo_empty_w}, 32'd1);
        reset = 1'b1;
        send_bits(1'b0, 8);
        check("post_active",   {31'd0, active_w},     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
